decode_pipe_stage: RTL and testbench

- Sits directly downstream of the frontend stage.
- Registers each fetched instruction (pc2, instr2, misaligned flag) into the decode pipe register and extracts RV32I register fields.
- Detects load-use hazards against the instruction currently in decode and drives the stall / stall-count handshake back to the frontend.
- Inserts bubbles on stall and flush; holds state on an external back-end stall.

---
 rtl/rv_decode_pkg.sv | 20 ++
 rtl/load_use_detect.sv | 10 +
 rtl/decode_pipe_stage.sv | 97 +++++++++
 tb/tb_decode_pipe_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_decode_pkg.sv
// rv_decode_pkg: RV32I opcode constants and decode pipe-register types
package rv_decode_pkg;
    localparam int DEC_PC_W = 32;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    typedef enum logic {RUN, STALL} decode_state_e;
    typedef struct packed {
        logic [DEC_PC_W-1:0] pc;
        logic [31:0]         instr;
        logic                valid;
        logic                misaligned;
    } dec_slot_t;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an incoming instruction that reads the destination of the load in decode
module load_use_detect (
    input  logic       is_load3,
    input  logic [4:0] rd_3,
    input  logic [4:0] rs1_2,
    input  logic [4:0] rs2_2,
    output logic       hazard
);
    assign hazard = is_load3 && (rd_3 != 5'd0) && (rs1_2 == rd_3 || rs2_2 == rd_3);
endmodule

// File: rtl/decode_pipe_stage.sv
// decode_pipe_stage: decode pipe register with load-use stall, flush bubbles and back-end freeze
module decode_pipe_stage
    import rv_decode_pkg::*;
#(
    parameter int          XLEN            = 32,
    parameter int          LOAD_USE_CYCLES = 1,
    parameter logic [31:0] NOP_INSTR       = rv_decode_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [XLEN-1:0] pc2,
    input  logic [31:0]     instr2,
    input  logic            instruction_addr_misaligned2,
    input  logic            flush,
    input  logic            stall_be,
    output logic            stall,
    output logic [1:0]      stallnum,
    output logic [XLEN-1:0] pc3,
    output logic [31:0]     instr3,
    output logic            valid3,
    output logic [4:0]      rs1_3,
    output logic [4:0]      rs2_3,
    output logic [4:0]      rd_3,
    output logic [6:0]      opcode3,
    output logic            is_load3,
    output logic            instruction_addr_misaligned3
);
    localparam logic [1:0] CNT_INIT = 2'(LOAD_USE_CYCLES - 1);

    dec_slot_t     slot_q, slot_d, bubble, fetched;
    decode_state_e state_q, state_d;
    logic [1:0]    cnt_q, cnt_d, stallnum_q, stallnum_d;
    logic          hazard, release_stall;

    load_use_detect u_detect (
        .is_load3 (is_load3),
        .rd_3     (rd_3),
        .rs1_2    (instr2[19:15]),
        .rs2_2    (instr2[24:20]),
        .hazard   (hazard)
    );

    // A bubble keeps the old PC so the slot still points somewhere sensible
    assign bubble        = '{pc: slot_q.pc, instr: NOP_INSTR, valid: 1'b0, misaligned: 1'b0};
    assign fetched       = '{pc: DEC_PC_W'(pc2), instr: instr2, valid: 1'b1, misaligned: instruction_addr_misaligned2};
    assign release_stall = cnt_q == 2'd0;

    always_comb begin
        slot_d     = slot_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        stallnum_d = stallnum_q;
        if (flush) begin
            slot_d     = bubble;
            state_d    = RUN;
            cnt_d      = '0;
            stallnum_d = '0;
        end else if (!stall_be) begin
            if (state_q == RUN) begin
                slot_d  = hazard ? bubble : fetched;
                state_d = hazard ? STALL : RUN;
                cnt_d   = hazard ? CNT_INIT : 2'd0;
            end else begin
                slot_d     = release_stall ? fetched : slot_q;
                state_d    = release_stall ? RUN : STALL;
                cnt_d      = release_stall ? 2'd0 : cnt_q - 2'd1;
                stallnum_d = release_stall ? 2'd0 : (stallnum_q == 2'b11 ? 2'b11 : stallnum_q + 2'd1);
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            slot_q     <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0, misaligned: 1'b0};
            state_q    <= RUN;
            cnt_q      <= '0;
            stallnum_q <= '0;
        end else begin
            slot_q     <= slot_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stallnum_q <= stallnum_d;
        end
    end

    assign stall                        = state_q == STALL;
    assign stallnum                     = stallnum_q;
    assign pc3                          = slot_q.pc[XLEN-1:0];
    assign instr3                       = slot_q.instr;
    assign valid3                       = slot_q.valid;
    assign instruction_addr_misaligned3 = slot_q.misaligned;
    assign rs1_3                        = slot_q.instr[19:15];
    assign rs2_3                        = slot_q.instr[24:20];
    assign rd_3                         = slot_q.instr[11:7];
    assign opcode3                      = slot_q.instr[6:0];
    assign is_load3                     = slot_q.valid && opcode3 == OP_LOAD;
endmodule

// File: tb/tb_decode_pipe_stage.sv
// tb_decode_pipe_stage: table, directed and random checks of decode_pipe_stage against a reference model
module tb_decode_pipe_stage;
    localparam logic [31:0] NOP     = 32'h00000013;
    localparam logic [31:0] ADDI    = 32'h00100093;
    localparam logic [31:0] LW5     = 32'h0000A283;
    localparam logic [31:0] LW0     = 32'h0000A003;
    localparam logic [31:0] ADD_RS1 = 32'h00228333;
    localparam logic [31:0] ADD_X0  = 32'h00200333;
    localparam logic [31:0] ADD_RS2 = 32'h00510333;
    localparam int NV = 21;

    logic        clk = 1'b0, nrst = 1'b0;
    logic [31:0] pc2 = '0, instr2 = NOP;
    logic        mis2 = 1'b0, flush = 1'b0, stall_be = 1'b0;

    logic        stall_a, valid3_a, is_load3_a, mis3_a;
    logic [1:0]  stallnum_a;
    logic [31:0] pc3_a, instr3_a;
    logic [4:0]  rs1_a, rs2_a, rd_a;
    logic [6:0]  op_a;
    logic        stall_b, valid3_b, is_load3_b, mis3_b;
    logic [1:0]  stallnum_b;
    logic [31:0] pc3_b, instr3_b;
    logic [4:0]  rs1_b, rs2_b, rd_b;
    logic [6:0]  op_b;

    int checks = 0, errors = 0;

    logic [31:0] m_pc [2];
    logic [31:0] m_instr [2];
    logic        m_valid [2];
    logic        m_mis [2];
    int          m_left [2];
    int          m_done [2];

    typedef struct {
        logic [31:0] pc, ins;
        logic        mis, fl, sb;
        logic [31:0] e_pc, e_ins;
        logic        e_v, e_mis, e_st;
        logic [1:0]  e_sn;
    } vec_t;
    vec_t tbl [NV];

    always #5 clk = ~clk;

    decode_pipe_stage dut_a (
        .clk(clk), .nrst(nrst), .pc2(pc2), .instr2(instr2),
        .instruction_addr_misaligned2(mis2), .flush(flush), .stall_be(stall_be),
        .stall(stall_a), .stallnum(stallnum_a), .pc3(pc3_a), .instr3(instr3_a),
        .valid3(valid3_a), .rs1_3(rs1_a), .rs2_3(rs2_a), .rd_3(rd_a), .opcode3(op_a),
        .is_load3(is_load3_a), .instruction_addr_misaligned3(mis3_a)
    );

    decode_pipe_stage #(.LOAD_USE_CYCLES(3)) dut_b (
        .clk(clk), .nrst(nrst), .pc2(pc2), .instr2(instr2),
        .instruction_addr_misaligned2(mis2), .flush(flush), .stall_be(stall_be),
        .stall(stall_b), .stallnum(stallnum_b), .pc3(pc3_b), .instr3(instr3_b),
        .valid3(valid3_b), .rs1_3(rs1_b), .rs2_3(rs2_b), .rd_3(rd_b), .opcode3(op_b),
        .is_load3(is_load3_b), .instruction_addr_misaligned3(mis3_b)
    );

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = '0; m_instr[k] = NOP; m_valid[k] = 1'b0; m_mis[k] = 1'b0;
            m_left[k] = 0; m_done[k] = 0;
        end
    endtask

    task automatic model_take(input int k);
        m_pc[k] = pc2; m_instr[k] = instr2; m_valid[k] = 1'b1; m_mis[k] = mis2;
    endtask

    task automatic model_bubble(input int k);
        m_instr[k] = NOP; m_valid[k] = 1'b0; m_mis[k] = 1'b0;
    endtask

    // One clock of the stage: m_left is how many stall cycles remain, m_done how many have elapsed
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic       ld;
            logic [4:0] rd;
            ld = m_valid[k] && m_instr[k][6:0] == 7'b0000011;
            rd = m_instr[k][11:7];
            if (flush) begin
                model_bubble(k); m_left[k] = 0; m_done[k] = 0;
            end else if (!stall_be) begin
                if (m_left[k] > 0) begin
                    m_left[k] = m_left[k] - 1;
                    m_done[k] = (m_left[k] == 0) ? 0 : (m_done[k] < 3 ? m_done[k] + 1 : 3);
                    if (m_left[k] == 0) model_take(k);
                end else if (ld && rd != 5'd0 && (instr2[19:15] == rd || instr2[24:20] == rd)) begin
                    model_bubble(k); m_left[k] = (k == 0) ? 1 : 3; m_done[k] = 0;
                end else begin
                    model_take(k);
                end
            end
        end
    endtask

    task automatic check_model();
        cmp("a_pc3", pc3_a, m_pc[0]);
        cmp("a_instr3", instr3_a, m_instr[0]);
        cmp("a_valid3", 32'(valid3_a), 32'(m_valid[0]));
        cmp("a_mis3", 32'(mis3_a), 32'(m_mis[0]));
        cmp("a_stall", 32'(stall_a), 32'(m_left[0] > 0));
        cmp("a_stallnum", 32'(stallnum_a), 32'(m_done[0]));
        cmp("a_rs1", 32'(rs1_a), 32'(m_instr[0][19:15]));
        cmp("a_rs2", 32'(rs2_a), 32'(m_instr[0][24:20]));
        cmp("a_rd", 32'(rd_a), 32'(m_instr[0][11:7]));
        cmp("a_opcode", 32'(op_a), 32'(m_instr[0][6:0]));
        cmp("a_is_load", 32'(is_load3_a), 32'(m_valid[0] && m_instr[0][6:0] == 7'b0000011));
        cmp("b_pc3", pc3_b, m_pc[1]);
        cmp("b_instr3", instr3_b, m_instr[1]);
        cmp("b_valid3", 32'(valid3_b), 32'(m_valid[1]));
        cmp("b_mis3", 32'(mis3_b), 32'(m_mis[1]));
        cmp("b_stall", 32'(stall_b), 32'(m_left[1] > 0));
        cmp("b_stallnum", 32'(stallnum_b), 32'(m_done[1]));
        cmp("b_rd", 32'(rd_b), 32'(m_instr[1][11:7]));
        cmp("b_is_load", 32'(is_load3_b), 32'(m_valid[1] && m_instr[1][6:0] == 7'b0000011));
    endtask

    task automatic check_reset_outputs(input string tag);
        cmp({tag, "_a_pc3"}, pc3_a, 32'd0);
        cmp({tag, "_a_instr3"}, instr3_a, NOP);
        cmp({tag, "_a_valid3"}, 32'(valid3_a), 32'd0);
        cmp({tag, "_a_stall"}, 32'(stall_a), 32'd0);
        cmp({tag, "_a_stallnum"}, 32'(stallnum_a), 32'd0);
        cmp({tag, "_a_mis3"}, 32'(mis3_a), 32'd0);
        cmp({tag, "_b_pc3"}, pc3_b, 32'd0);
        cmp({tag, "_b_instr3"}, instr3_b, NOP);
        cmp({tag, "_b_valid3"}, 32'(valid3_b), 32'd0);
        cmp({tag, "_b_stall"}, 32'(stall_b), 32'd0);
        cmp({tag, "_b_stallnum"}, 32'(stallnum_b), 32'd0);
    endtask

    task automatic drive(input logic [31:0] p, input logic [31:0] i, input logic m, input logic f, input logic s);
        pc2 = p; instr2 = i; mis2 = m; flush = f; stall_be = s;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic step_b(input string nm, input logic [31:0] p, input logic [31:0] i, input logic sb,
                          input logic [31:0] e_pc, input logic [31:0] e_ins, input logic e_st, input logic [1:0] e_sn);
        drive(p, i, 1'b0, 1'b0, sb);
        cmp({nm, "_pc3"}, pc3_b, e_pc);
        cmp({nm, "_instr3"}, instr3_b, e_ins);
        cmp({nm, "_stall"}, 32'(stall_b), 32'(e_st));
        cmp({nm, "_stallnum"}, 32'(stallnum_b), 32'(e_sn));
    endtask

    function automatic logic [4:0] rsel();
        case ($urandom_range(0, 3))
            0: return 5'd0;
            1: return 5'd2;
            2: return 5'd5;
            default: return 5'd6;
        endcase
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [4:0] d, s1, s2;
        d = rsel(); s1 = rsel(); s2 = rsel();
        case ($urandom_range(0, 2))
            0: return {12'h004, s1, 3'b010, d, 7'b0000011};
            1: return {7'h00, s2, s1, 3'b000, d, 7'b0110011};
            default: return {12'h001, s1, 3'b000, d, 7'b0010011};
        endcase
    endfunction

    initial begin
        tbl[0]  = '{0,  ADDI,    0, 0, 0, 0,  ADDI,    1, 0, 0, 0};
        tbl[1]  = '{1,  ADDI,    0, 0, 0, 1,  ADDI,    1, 0, 0, 0};
        tbl[2]  = '{2,  LW5,     0, 0, 0, 2,  LW5,     1, 0, 0, 0};
        tbl[3]  = '{3,  ADD_RS1, 0, 0, 0, 2,  NOP,     0, 0, 1, 0};
        tbl[4]  = '{3,  ADD_RS1, 0, 0, 0, 3,  ADD_RS1, 1, 0, 0, 0};
        tbl[5]  = '{4,  LW0,     0, 0, 0, 4,  LW0,     1, 0, 0, 0};
        tbl[6]  = '{5,  ADD_X0,  0, 0, 0, 5,  ADD_X0,  1, 0, 0, 0};
        tbl[7]  = '{6,  LW5,     0, 0, 0, 6,  LW5,     1, 0, 0, 0};
        tbl[8]  = '{7,  ADD_RS2, 0, 1, 0, 6,  NOP,     0, 0, 0, 0};
        tbl[9]  = '{7,  ADD_RS2, 1, 0, 0, 7,  ADD_RS2, 1, 1, 0, 0};
        tbl[10] = '{8,  LW5,     0, 1, 0, 7,  NOP,     0, 0, 0, 0};
        tbl[11] = '{8,  LW5,     0, 0, 0, 8,  LW5,     1, 0, 0, 0};
        tbl[12] = '{9,  ADD_RS1, 0, 0, 1, 8,  LW5,     1, 0, 0, 0};
        tbl[13] = '{9,  ADD_RS1, 0, 0, 0, 8,  NOP,     0, 0, 1, 0};
        tbl[14] = '{9,  ADD_RS1, 0, 0, 1, 8,  NOP,     0, 0, 1, 0};
        tbl[15] = '{9,  ADD_RS1, 0, 0, 1, 8,  NOP,     0, 0, 1, 0};
        tbl[16] = '{9,  ADD_RS1, 0, 0, 0, 9,  ADD_RS1, 1, 0, 0, 0};
        tbl[17] = '{10, ADDI,    0, 0, 0, 10, ADDI,    1, 0, 0, 0};
        tbl[18] = '{11, LW5,     0, 0, 0, 11, LW5,     1, 0, 0, 0};
        tbl[19] = '{12, ADD_RS2, 0, 0, 0, 11, NOP,     0, 0, 1, 0};
        tbl[20] = '{12, ADD_RS2, 0, 0, 0, 12, ADD_RS2, 1, 0, 0, 0};

        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        check_model();
        nrst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].pc, tbl[i].ins, tbl[i].mis, tbl[i].fl, tbl[i].sb);
            cmp($sformatf("tbl%0d_pc3", i), pc3_a, tbl[i].e_pc);
            cmp($sformatf("tbl%0d_instr3", i), instr3_a, tbl[i].e_ins);
            cmp($sformatf("tbl%0d_valid3", i), 32'(valid3_a), 32'(tbl[i].e_v));
            cmp($sformatf("tbl%0d_mis3", i), 32'(mis3_a), 32'(tbl[i].e_mis));
            cmp($sformatf("tbl%0d_stall", i), 32'(stall_a), 32'(tbl[i].e_st));
            cmp($sformatf("tbl%0d_stallnum", i), 32'(stallnum_a), 32'(tbl[i].e_sn));
        end

        do_reset();
        step_b("l3_ld",   20, LW5,     0, 20, LW5,     0, 0);
        step_b("l3_s0",   21, ADD_RS1, 0, 20, NOP,     1, 0);
        step_b("l3_s1",   21, ADD_RS1, 0, 20, NOP,     1, 1);
        step_b("l3_s2",   21, ADD_RS1, 0, 20, NOP,     1, 2);
        step_b("l3_rel",  21, ADD_RS1, 0, 21, ADD_RS1, 0, 0);
        step_b("be_ld",   22, LW5,     0, 22, LW5,     0, 0);
        step_b("be_s0",   23, ADD_RS1, 0, 22, NOP,     1, 0);
        step_b("be_hold1",23, ADD_RS1, 1, 22, NOP,     1, 0);
        step_b("be_hold2",23, ADD_RS1, 1, 22, NOP,     1, 0);
        step_b("be_s1",   23, ADD_RS1, 0, 22, NOP,     1, 1);
        step_b("be_s2",   23, ADD_RS1, 0, 22, NOP,     1, 2);
        step_b("be_rel",  23, ADD_RS1, 0, 23, ADD_RS1, 0, 0);

        drive(30, LW5, 1'b0, 1'b0, 1'b0);
        drive(31, ADD_RS1, 1'b0, 1'b0, 1'b0);
        cmp("mid_stall_b", 32'(stall_b), 32'd1);
        #2 nrst = 1'b0;
        model_reset();
        #1 check_reset_outputs("async");
        check_model();
        @(negedge clk);
        nrst = 1'b1;

        for (int i = 0; i < 400; i++)
            drive($urandom, rnd_instr(), $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 6) == 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
